health_controller: RTL and testbench
====================================

# health_controller

Owns both fighters' health for a round and sequences the health-bar datapath. Accepts damage requests from the Ryu and Akuma hit-detection logic, arbitrates them one per cycle, and keeps a target health per fighter. A displayed health drains toward the target once per frame. It detects KO and drives the round-state outputs consumed by the health-bar renderer and game FSM.

## Interface
Parameters:
- MAX_HEALTH, 200: full health; bar width in pixels; must be ≤ 255.
- DRAIN_STEP, 2: max displayed-health decrement per frame_tick.
- KO_FRAMES, 120: frame_ticks spent in KO before round_over asserts.

Ports:
- Clk  in  1  system clock; one clock domain; all logic on posedge Clk.
- Reset  in  1  synchronous, active-high.
- frame_tick  in  1  one-cycle pulse per video frame (VSYNC edge, already synchronised to Clk).
- round_start  in  1  one-cycle pulse; begins a new round.
- ryu_hit_req  in  1  Ryu has landed a hit on Akuma; held until ryu_hit_ack.
- ryu_hit_dmg  in  8  damage for ryu_hit_req; stable while req is high.
- akuma_hit_req  in  1  Akuma has landed a hit on Ryu; held until akuma_hit_ack.
- akuma_hit_dmg  in  8  damage for akuma_hit_req.
- ryu_hit_ack  out  1  one-cycle pulse; Ryu's hit was accepted.
- akuma_hit_ack  out  1  one-cycle pulse; Akuma's hit was accepted.
- RyuHealth  out  8  displayed Ryu health, feeds the health-bar renderer.
- AkumaHealth  out  8  displayed Akuma health.
- ko  out  1  high in KO_DRAIN and KO.
- winner  out  2  00 none, 01 Ryu, 10 Akuma.
- round_over  out  1  level; high once KO_FRAMES have elapsed in KO.

## Operation
- Reset values:
  - RyuHealth = AkumaHealth = MAX_HEALTH; both targets = MAX_HEALTH.
  - ko = 0, winner = 00, round_over = 0, both acks 0.
  - Round-robin pointer favours Ryu; state = ROUND_INIT.
- FSM states:
  - ROUND_INIT: load targets and displays with MAX_HEALTH; clear winner, round_over and the KO counter. Next state: FIGHT.
  - FIGHT: accepts hits. If an accepted hit makes a target 0, go to KO_DRAIN.
  - KO_DRAIN: no hits accepted. When both displays equal their targets, go to KO.
  - KO: count frame_ticks. When the count reaches KO_FRAMES, set round_over and hold it.
  - round_start in any state: go to ROUND_INIT next cycle. This includes aborting mid-FIGHT.
- Hit acceptance:
  - Applies in FIGHT only, at most one hit per cycle.
  - A requester is eligible when its req is high and its ack is not high in the current cycle. This prevents double acceptance of a held req.
  - Both eligible: grant the one not granted last, then flip the pointer.
- Damage:
  - Ryu's hit lowers the Akuma target; Akuma's hit lowers the Ryu target.
  - Subtraction saturates at 0 (dmg ≥ target gives 0). dmg = 0 is accepted with no change.
- Winner: set at the FIGHT→KO_DRAIN transition. Akuma target 0 gives 01; Ryu target 0 gives 10. A simultaneous KO cannot occur because only one hit is accepted per cycle.
- Drain, on each frame_tick in FIGHT, KO_DRAIN or KO, per fighter:
  - display -= min(DRAIN_STEP, display − target).
  - Display never goes below target. Display equal to target is unchanged.
- Requests arriving outside FIGHT are not acked. They stay pending until a later FIGHT.

## Timing
- Req sampled high in cycle N with a grant: ack is high in N+1 and the target updates at the N+1 edge. The requester may drop req in N+1.
- The first drain step is visible on the output one cycle after the next frame_tick.
- Fatal hit accepted in cycle N: ko and winner are high from N+1.
- round_start in cycle N: ROUND_INIT in N+1, FIGHT in N+2. Outputs show MAX_HEALTH from N+2. round_start takes priority over a simultaneous hit, which is not acked.
- All outputs are registered.

## Structure
- Package health_pkg holds:
  - the ctrl_state_t enum (ROUND_INIT, FIGHT, KO_DRAIN, KO);
  - the winner_t enum;
  - the MAX_HEALTH default constant.
- Sub-module health_drain, instantiated once per fighter:
  - holds the target and display registers;
  - saturating damage apply, frame_tick drain, and a load-full input;
  - outputs target_zero and settled (display == target).

## Test plan
- Reset, then 3 frame_ticks → RyuHealth = AkumaHealth = 200, ko = 0, winner = 00, no acks.
- ryu_hit_req with dmg = 10 held 4 cycles → exactly one ryu_hit_ack pulse. Akuma target = 190; AkumaHealth reaches 190 after 5 frame_ticks (200, 198, …, 190).
- Both reqs rise in the same cycle, dmg 5 each, after reset → Ryu acked first, Akuma acked next eligible cycle. Repeat with both high → Akuma granted first.
- Akuma target 7, ryu_hit_dmg = 50 → target 0, ko = 1 next cycle, winner = 01. A simultaneous akuma_hit_req is never acked. AkumaHealth drains to 0, then KO; round_over after 120 frame_ticks.
- round_start during FIGHT with healths 150/80 → both outputs 200 two cycles later, ko = 0, round_over = 0, winner = 00.
- Reset asserted mid-KO_DRAIN → all outputs at reset values the next cycle. A pending req is not acked until FIGHT.

Source files
------------

// File: rtl/health_pkg.sv
// health_pkg: shared state/winner encodings and the default full-health value
package health_pkg;
    localparam int MAX_HEALTH_DEFAULT = 200;
    typedef enum logic [1:0] {ROUND_INIT, FIGHT, KO_DRAIN, KO} ctrl_state_t;
    typedef enum logic [1:0] {WIN_NONE = 2'b00, WIN_RYU = 2'b01, WIN_AKUMA = 2'b10} winner_t;
endpackage

// File: rtl/health_drain.sv
// health_drain: one fighter's target health and the displayed health that drains toward it
module health_drain #(
    parameter int MAX_HEALTH = 200,
    parameter int DRAIN_STEP = 2
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       load_full,
    input  logic       drain_tick,
    input  logic       hit,
    input  logic [7:0] dmg,
    output logic [7:0] display,
    output logic       lethal,
    output logic       target_zero,
    output logic       settled
);
    localparam logic [7:0] FULL = 8'(MAX_HEALTH);
    localparam logic [7:0] STEP = 8'(DRAIN_STEP);
    logic [7:0] target, gap, step;
    // display never drops below target, so gap cannot underflow; lethal flags a hit that saturates to 0
    always_comb begin
        gap         = display - target;
        step        = gap > STEP ? STEP : gap;
        lethal      = dmg >= target;
        target_zero = target == '0;
        settled     = display == target;
    end
    // saturating damage on the target and per-frame drain of the display
    always_ff @(posedge vga_clk) begin
        if (reset || load_full) begin
            target  <= FULL;
            display <= FULL;
        end else begin
            if (hit) target <= lethal ? '0 : target - dmg;
            if (drain_tick) display <= display - step;
        end
    end
endmodule

// File: rtl/health_controller.sv
// health_controller: arbitrates hits, tracks both fighters' health and sequences the round FSM
module health_controller import health_pkg::*; #(
    parameter int MAX_HEALTH = MAX_HEALTH_DEFAULT,
    parameter int DRAIN_STEP = 2,
    parameter int KO_FRAMES  = 120
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       round_start,
    input  logic       ryu_hit_req,
    input  logic [7:0] ryu_hit_dmg,
    input  logic       akuma_hit_req,
    input  logic [7:0] akuma_hit_dmg,
    output logic       ryu_hit_ack,
    output logic       akuma_hit_ack,
    output logic [7:0] RyuHealth,
    output logic [7:0] AkumaHealth,
    output logic       ko,
    output logic [1:0] winner,
    output logic       round_over
);
    localparam int CW = $clog2(KO_FRAMES + 1);
    ctrl_state_t state, state_n;
    winner_t winner_q;
    logic [CW-1:0] ko_cnt;
    logic prefer_akuma, ryu_elig, akuma_elig, fight, contend, grant_ryu, grant_akuma, fatal;
    logic load_full, drain_tick;
    logic ryu_lethal, ryu_zero, ryu_settled, akuma_lethal, akuma_zero, akuma_settled;
    assign load_full  = state == ROUND_INIT;
    assign drain_tick = frame_tick && state != ROUND_INIT;
    assign winner     = winner_q;
    health_drain #(.MAX_HEALTH(MAX_HEALTH), .DRAIN_STEP(DRAIN_STEP)) u_ryu (
        .vga_clk(Clk), .reset(Reset), .load_full(load_full), .drain_tick(drain_tick),
        .hit(grant_akuma), .dmg(akuma_hit_dmg), .display(RyuHealth),
        .lethal(ryu_lethal), .target_zero(ryu_zero), .settled(ryu_settled)
    );
    health_drain #(.MAX_HEALTH(MAX_HEALTH), .DRAIN_STEP(DRAIN_STEP)) u_akuma (
        .vga_clk(Clk), .reset(Reset), .load_full(load_full), .drain_tick(drain_tick),
        .hit(grant_ryu), .dmg(ryu_hit_dmg), .display(AkumaHealth),
        .lethal(akuma_lethal), .target_zero(akuma_zero), .settled(akuma_settled)
    );
    // round-robin grant of one eligible hit per FIGHT cycle and next-state selection
    always_comb begin
        ryu_elig    = ryu_hit_req && !ryu_hit_ack;
        akuma_elig  = akuma_hit_req && !akuma_hit_ack;
        fight       = state == FIGHT && !round_start;
        contend     = fight && ryu_elig && akuma_elig;
        grant_ryu   = fight && ryu_elig && (!akuma_elig || !prefer_akuma);
        grant_akuma = fight && akuma_elig && (!ryu_elig || prefer_akuma);
        fatal       = (grant_ryu && akuma_lethal) || (grant_akuma && ryu_lethal);
        state_n     = state;
        if (round_start) state_n = ROUND_INIT;
        else if (state == ROUND_INIT) state_n = FIGHT;
        else if (state == FIGHT && fatal) state_n = KO_DRAIN;
        else if (state == KO_DRAIN && ryu_settled && akuma_settled && (ryu_zero || akuma_zero)) state_n = KO;
    end
    // state, acks, pointer, winner and KO frame counting
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= ROUND_INIT;
            prefer_akuma  <= 1'b0;
            ryu_hit_ack   <= 1'b0;
            akuma_hit_ack <= 1'b0;
            ko            <= 1'b0;
            winner_q      <= WIN_NONE;
            round_over    <= 1'b0;
            ko_cnt        <= '0;
        end else begin
            state         <= state_n;
            ryu_hit_ack   <= grant_ryu;
            akuma_hit_ack <= grant_akuma;
            ko            <= state_n == KO_DRAIN || state_n == KO;
            if (contend) prefer_akuma <= !prefer_akuma;
            if (state == ROUND_INIT) begin
                winner_q   <= WIN_NONE;
                round_over <= 1'b0;
                ko_cnt     <= '0;
            end else if (state == FIGHT && state_n == KO_DRAIN) begin
                winner_q <= grant_ryu ? WIN_RYU : WIN_AKUMA;
            end else if (state == KO && frame_tick && !round_over) begin
                ko_cnt     <= ko_cnt + 1'b1;
                round_over <= ko_cnt == CW'(KO_FRAMES - 1);
            end
        end
    end
endmodule

// File: tb/tb_health_controller.sv
// tb_health_controller: directed scenario tests for health_controller
module tb_health_controller;
    logic       Clk = 1'b0;
    logic       Reset, frame_tick, round_start;
    logic       ryu_hit_req, akuma_hit_req;
    logic [7:0] ryu_hit_dmg, akuma_hit_dmg;
    logic       ryu_hit_ack, akuma_hit_ack, ko, round_over;
    logic [7:0] RyuHealth, AkumaHealth;
    logic [1:0] winner;
    int total = 0;
    int bad = 0;
    int ryu_acks = 0;
    int akuma_acks = 0;

    health_controller dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .round_start(round_start),
        .ryu_hit_req(ryu_hit_req), .ryu_hit_dmg(ryu_hit_dmg),
        .akuma_hit_req(akuma_hit_req), .akuma_hit_dmg(akuma_hit_dmg),
        .ryu_hit_ack(ryu_hit_ack), .akuma_hit_ack(akuma_hit_ack),
        .RyuHealth(RyuHealth), .AkumaHealth(AkumaHealth),
        .ko(ko), .winner(winner), .round_over(round_over)
    );

    always #5 Clk = ~Clk;

    // count ack pulses just after each edge
    always @(posedge Clk) begin
        #1;
        if (ryu_hit_ack) ryu_acks++;
        if (akuma_hit_ack) akuma_acks++;
    end

    task automatic step();
        @(negedge Clk);
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        int ra, aa;
        do_reset();
        ra = ryu_acks;
        aa = akuma_acks;
        for (int i = 0; i < 3; i++) tick();
        total++; if (RyuHealth !== 8'd200) begin bad++; $display("FAIL reset_ryu_health got %0d want 200", RyuHealth); end
        total++; if (AkumaHealth !== 8'd200) begin bad++; $display("FAIL reset_akuma_health got %0d want 200", AkumaHealth); end
        total++; if (ko !== 1'b0) begin bad++; $display("FAIL reset_ko got %0b want 0", ko); end
        total++; if (winner !== 2'b00) begin bad++; $display("FAIL reset_winner got %0b want 00", winner); end
        total++; if (round_over !== 1'b0) begin bad++; $display("FAIL reset_round_over got %0b want 0", round_over); end
        total++; if (ryu_acks - ra + akuma_acks - aa !== 0) begin bad++; $display("FAIL reset_acks got %0d want 0", ryu_acks - ra + akuma_acks - aa); end
    endtask

    task automatic test_single_hit();
        int ra;
        do_reset();
        ra = ryu_acks;
        ryu_hit_dmg = 8'd10;
        ryu_hit_req = 1'b1;
        step();
        total++; if (ryu_hit_ack !== 1'b1) begin bad++; $display("FAIL hit_ack_latency got %0b want 1", ryu_hit_ack); end
        ryu_hit_req = 1'b0;
        for (int i = 0; i < 3; i++) step();
        total++; if (ryu_acks - ra !== 1) begin bad++; $display("FAIL hit_ack_count got %0d want 1", ryu_acks - ra); end
        total++; if (AkumaHealth !== 8'd200) begin bad++; $display("FAIL hit_no_tick_display got %0d want 200", AkumaHealth); end
        tick();
        total++; if (AkumaHealth !== 8'd198) begin bad++; $display("FAIL hit_first_drain got %0d want 198", AkumaHealth); end
        for (int i = 0; i < 4; i++) tick();
        total++; if (AkumaHealth !== 8'd190) begin bad++; $display("FAIL hit_drained got %0d want 190", AkumaHealth); end
        tick();
        total++; if (AkumaHealth !== 8'd190) begin bad++; $display("FAIL hit_settled_hold got %0d want 190", AkumaHealth); end
        total++; if (RyuHealth !== 8'd200) begin bad++; $display("FAIL hit_other_fighter got %0d want 200", RyuHealth); end
    endtask

    task automatic test_arbitration();
        do_reset();
        ryu_hit_dmg = 8'd5;
        akuma_hit_dmg = 8'd5;
        ryu_hit_req = 1'b1;
        akuma_hit_req = 1'b1;
        step();
        total++; if ({ryu_hit_ack, akuma_hit_ack} !== 2'b10) begin bad++; $display("FAIL arb1_first got %0b want 10", {ryu_hit_ack, akuma_hit_ack}); end
        ryu_hit_req = 1'b0;
        step();
        total++; if ({ryu_hit_ack, akuma_hit_ack} !== 2'b01) begin bad++; $display("FAIL arb1_second got %0b want 01", {ryu_hit_ack, akuma_hit_ack}); end
        akuma_hit_req = 1'b0;
        step();
        ryu_hit_req = 1'b1;
        akuma_hit_req = 1'b1;
        step();
        total++; if ({ryu_hit_ack, akuma_hit_ack} !== 2'b01) begin bad++; $display("FAIL arb2_first got %0b want 01", {ryu_hit_ack, akuma_hit_ack}); end
        akuma_hit_req = 1'b0;
        step();
        total++; if ({ryu_hit_ack, akuma_hit_ack} !== 2'b10) begin bad++; $display("FAIL arb2_second got %0b want 10", {ryu_hit_ack, akuma_hit_ack}); end
        ryu_hit_req = 1'b0;
        step();
        for (int i = 0; i < 6; i++) tick();
        total++; if (RyuHealth !== 8'd190) begin bad++; $display("FAIL arb_ryu_health got %0d want 190", RyuHealth); end
        total++; if (AkumaHealth !== 8'd190) begin bad++; $display("FAIL arb_akuma_health got %0d want 190", AkumaHealth); end
    endtask

    task automatic test_ko();
        int aa, n;
        do_reset();
        ryu_hit_dmg = 8'd193;
        ryu_hit_req = 1'b1;
        step();
        ryu_hit_req = 1'b0;
        step();
        total++; if (ko !== 1'b0) begin bad++; $display("FAIL ko_early got %0b want 0", ko); end
        aa = akuma_acks;
        ryu_hit_dmg = 8'd50;
        akuma_hit_dmg = 8'd3;
        ryu_hit_req = 1'b1;
        akuma_hit_req = 1'b1;
        step();
        total++; if (ryu_hit_ack !== 1'b1) begin bad++; $display("FAIL ko_fatal_ack got %0b want 1", ryu_hit_ack); end
        total++; if (ko !== 1'b1) begin bad++; $display("FAIL ko_flag got %0b want 1", ko); end
        total++; if (winner !== 2'b01) begin bad++; $display("FAIL ko_winner got %0b want 01", winner); end
        ryu_hit_req = 1'b0;
        n = 0;
        while (AkumaHealth !== 8'd0 && n < 150) begin
            tick();
            n++;
        end
        total++; if (n !== 100) begin bad++; $display("FAIL ko_drain_ticks got %0d want 100", n); end
        total++; if (RyuHealth !== 8'd200) begin bad++; $display("FAIL ko_ryu_untouched got %0d want 200", RyuHealth); end
        for (int i = 0; i < 119; i++) tick();
        total++; if (round_over !== 1'b0) begin bad++; $display("FAIL ko_round_over_early got %0b want 0", round_over); end
        tick();
        total++; if (round_over !== 1'b1) begin bad++; $display("FAIL ko_round_over got %0b want 1", round_over); end
        for (int i = 0; i < 3; i++) tick();
        total++; if (round_over !== 1'b1) begin bad++; $display("FAIL ko_round_over_hold got %0b want 1", round_over); end
        total++; if (ko !== 1'b1) begin bad++; $display("FAIL ko_hold got %0b want 1", ko); end
        total++; if (akuma_acks - aa !== 0) begin bad++; $display("FAIL ko_loser_acked got %0d want 0", akuma_acks - aa); end
        akuma_hit_req = 1'b0;
        step();
    endtask

    task automatic test_round_start();
        do_reset();
        akuma_hit_dmg = 8'd50;
        akuma_hit_req = 1'b1;
        step();
        akuma_hit_req = 1'b0;
        ryu_hit_dmg = 8'd120;
        ryu_hit_req = 1'b1;
        step();
        ryu_hit_req = 1'b0;
        for (int i = 0; i < 60; i++) tick();
        total++; if (RyuHealth !== 8'd150) begin bad++; $display("FAIL rs_ryu_before got %0d want 150", RyuHealth); end
        total++; if (AkumaHealth !== 8'd80) begin bad++; $display("FAIL rs_akuma_before got %0d want 80", AkumaHealth); end
        ryu_hit_dmg = 8'd9;
        ryu_hit_req = 1'b1;
        round_start = 1'b1;
        step();
        round_start = 1'b0;
        total++; if (ryu_hit_ack !== 1'b0) begin bad++; $display("FAIL rs_hit_blocked got %0b want 0", ryu_hit_ack); end
        step();
        total++; if ({RyuHealth, AkumaHealth} !== {8'd200, 8'd200}) begin bad++; $display("FAIL rs_health got %0d/%0d want 200/200", RyuHealth, AkumaHealth); end
        total++; if ({ko, winner, round_over} !== 4'b0000) begin bad++; $display("FAIL rs_flags got %0b want 0000", {ko, winner, round_over}); end
        total++; if (ryu_hit_ack !== 1'b0) begin bad++; $display("FAIL rs_init_no_ack got %0b want 0", ryu_hit_ack); end
        step();
        total++; if (ryu_hit_ack !== 1'b1) begin bad++; $display("FAIL rs_pending_ack got %0b want 1", ryu_hit_ack); end
        ryu_hit_req = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        ryu_hit_dmg = 8'd255;
        ryu_hit_req = 1'b1;
        step();
        ryu_hit_req = 1'b0;
        total++; if ({ko, winner} !== 3'b101) begin bad++; $display("FAIL rmd_ko got %0b want 101", {ko, winner}); end
        akuma_hit_dmg = 8'd4;
        akuma_hit_req = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        total++; if (AkumaHealth !== 8'd194) begin bad++; $display("FAIL rmd_mid_drain got %0d want 194", AkumaHealth); end
        Reset = 1'b1;
        step();
        total++; if ({RyuHealth, AkumaHealth} !== {8'd200, 8'd200}) begin bad++; $display("FAIL rmd_health got %0d/%0d want 200/200", RyuHealth, AkumaHealth); end
        total++; if ({ko, winner, round_over, ryu_hit_ack, akuma_hit_ack} !== 6'b0) begin bad++; $display("FAIL rmd_flags got %0b want 000000", {ko, winner, round_over, ryu_hit_ack, akuma_hit_ack}); end
        Reset = 1'b0;
        step();
        total++; if (akuma_hit_ack !== 1'b0) begin bad++; $display("FAIL rmd_init_no_ack got %0b want 0", akuma_hit_ack); end
        step();
        total++; if (akuma_hit_ack !== 1'b1) begin bad++; $display("FAIL rmd_pending_ack got %0b want 1", akuma_hit_ack); end
        akuma_hit_req = 1'b0;
        step();
        total++; if (RyuHealth !== 8'd200) begin bad++; $display("FAIL rmd_no_tick_display got %0d want 200", RyuHealth); end
    endtask

    initial begin
        Reset = 1'b1;
        frame_tick = 1'b0;
        round_start = 1'b0;
        ryu_hit_req = 1'b0;
        akuma_hit_req = 1'b0;
        ryu_hit_dmg = 8'd0;
        akuma_hit_dmg = 8'd0;
        step();
        test_reset();
        test_single_hit();
        test_arbitration();
        test_ko();
        test_round_start();
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
